// File: rtl/bcd_score_counter.sv
// Per-player BCD score counter for the HEX displays: edge-counts a scoring
// request, keeps a binary copy, blanks leading zeros and flags a sticky win.
module bcd_score_counter #(
    parameter int  DIGITS    = 3,
    parameter int  WIN_SCORE = 7,
    parameter bit  BLANK_LZ  = 1'b1,
    localparam int BIN_W     = $clog2(10 ** DIGITS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  inc,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   digits,
    output logic [BIN_W-1:0]      score_bin,
    output logic                  win,
    output logic                  inc_ack
);

    typedef enum logic {
        COUNTING = 1'b0,
        WON      = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [DIGITS-1:0][3:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]         bin_q, bin_d;
    logic                     inc_q;
    logic                     acc_q;
    logic                     ack_q;
    logic                     accept;
    logic                     carry;

    assign accept = inc & ~inc_q & (state_q == COUNTING) & ~clr;

    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        carry   = accept;

        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (bcd_q[i] == 4'd9) begin
                    bcd_d[i] = 4'd0;
                end else begin
                    bcd_d[i] = bcd_q[i] + 4'd1;
                    carry    = 1'b0;
                end
            end
        end

        if (accept) begin
            bin_d = bin_q + 1'b1;
        end

        case (state_q)
            COUNTING: if (accept && bin_q == BIN_W'(WIN_SCORE - 1)) state_d = WON;
            WON:      state_d = WON;
            default:  state_d = COUNTING;
        endcase

        if (clr) begin
            state_d = COUNTING;
            bcd_d   = '0;
            bin_d   = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= COUNTING;
            bcd_q   <= '0;
            bin_q   <= '0;
            inc_q   <= 1'b0;
            acc_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            inc_q   <= inc;
            acc_q   <= accept;
            ack_q   <= clr ? 1'b0 : acc_q;
        end
    end

    // Walk from the top digit down; blank while every digit seen so far is zero.
    always_comb begin
        logic lead;
        lead   = 1'b1;
        digits = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (BLANK_LZ && lead && i != 0 && bcd_q[i] == 4'd0) begin
                digits[4*i +: 4] = 4'hF;
            end else begin
                digits[4*i +: 4] = bcd_q[i];
                lead             = 1'b0;
            end
        end
    end

    assign score_bin = bin_q;
    assign win       = (state_q == WON);
    assign inc_ack   = ack_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Scoreboard bench: three counter configurations share one clock; a reference
// model predicts each cycle's outputs, which are queued and compared after the edge.
module tb_bcd_score_counter;

    logic clk;
    logic reset_n;
    logic inc_s [3];
    logic clr_s [3];

    logic [11:0] dg_a, dg_b;
    logic [7:0]  dg_c;
    logic [9:0]  bin_a, bin_b;
    logic [6:0]  bin_c;
    logic        win_a, win_b, win_c;
    logic        ack_a, ack_b, ack_c;

    bcd_score_counter #(.DIGITS(3), .WIN_SCORE(7), .BLANK_LZ(1'b1)) u_a (
        .clk(clk), .reset_n(reset_n), .inc(inc_s[0]), .clr(clr_s[0]),
        .digits(dg_a), .score_bin(bin_a), .win(win_a), .inc_ack(ack_a));

    bcd_score_counter #(.DIGITS(3), .WIN_SCORE(150), .BLANK_LZ(1'b1)) u_b (
        .clk(clk), .reset_n(reset_n), .inc(inc_s[1]), .clr(clr_s[1]),
        .digits(dg_b), .score_bin(bin_b), .win(win_b), .inc_ack(ack_b));

    bcd_score_counter #(.DIGITS(2), .WIN_SCORE(50), .BLANK_LZ(1'b0)) u_c (
        .clk(clk), .reset_n(reset_n), .inc(inc_s[2]), .clr(clr_s[2]),
        .digits(dg_c), .score_bin(bin_c), .win(win_c), .inc_ack(ack_c));

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] dg;
        int          bin;
        logic        w;
        logic        ak;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    const int nd [3] = '{3, 3, 2};
    const int ws [3] = '{7, 150, 50};
    const bit bl [3] = '{1'b1, 1'b1, 1'b0};

    int sc [3];
    bit wn [3];
    bit iq [3];
    bit p1 [3];
    bit ak [3];

    function automatic logic [23:0] enc(input int s, input int n, input bit b);
        int p;
        p   = 1;
        enc = '0;
        for (int i = 0; i < n; i++) begin
            if (b && i > 0 && s < p) enc[4*i +: 4] = 4'hF;
            else                     enc[4*i +: 4] = 4'((s / p) % 10);
            p = p * 10;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        bit acc;
        for (int k = 0; k < 3; k++) begin
            if (!reset_n) begin
                sc[k] = 0; wn[k] = 0; iq[k] = 0; p1[k] = 0; ak[k] = 0;
            end else begin
                acc   = inc_s[k] && !iq[k] && !wn[k] && !clr_s[k];
                ak[k] = clr_s[k] ? 1'b0 : p1[k];
                p1[k] = acc;
                iq[k] = inc_s[k];
                if (clr_s[k]) begin
                    sc[k] = 0; wn[k] = 0;
                end else if (acc) begin
                    sc[k]++;
                    if (sc[k] == ws[k]) wn[k] = 1'b1;
                end
            end
            e.dg  = enc(sc[k], nd[k], bl[k]);
            e.bin = sc[k];
            e.w   = wn[k];
            e.ak  = ak[k];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            logic [23:0] od;
            int          ob;
            logic        ow, oa;
            e = sb.pop_front();
            case (k)
                0:       begin od = {12'h0, dg_a}; ob = int'(bin_a); ow = win_a; oa = ack_a; end
                1:       begin od = {12'h0, dg_b}; ob = int'(bin_b); ow = win_b; oa = ack_b; end
                default: begin od = {16'h0, dg_c}; ob = int'(bin_c); ow = win_c; oa = ack_c; end
            endcase
            check($sformatf("u%0d.digits", k),    32'(od), 32'(e.dg));
            check($sformatf("u%0d.score_bin", k), ob,      e.bin);
            check($sformatf("u%0d.win", k),       32'(ow), 32'(e.w));
            check($sformatf("u%0d.inc_ack", k),   32'(oa), 32'(e.ak));
        end
    endtask

    task automatic pulse(input int k);
        inc_s[k] = 1'b1;
        tick();
        inc_s[k] = 1'b0;
        tick();
    endtask

    initial begin
        clk     = 1'b0;
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            inc_s[k] = 1'b0;
            clr_s[k] = 1'b0;
        end

        // Reset and idle.
        tick();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("a_reset_digits", 32'(dg_a), 32'h0FF0);
        check("c_reset_digits", 32'(dg_c), 32'h00);

        // Held request counts once, then a short pulse.
        inc_s[0] = 1'b1;
        repeat (5) tick();
        inc_s[0] = 1'b0;
        repeat (3) tick();
        pulse(0);

        // Climb to the win score, then further requests are ignored.
        repeat (5) pulse(0);
        check("a_win_digits", 32'(dg_a), 32'h0FF7);
        check("a_win_flag", 32'(win_a), 32'h1);
        repeat (3) pulse(0);
        check("a_frozen_bin", 32'(bin_a), 32'd7);

        // Clear, reach 3, then clear on the same cycle as a rising request.
        clr_s[0] = 1'b1;
        tick();
        clr_s[0] = 1'b0;
        tick();
        repeat (3) pulse(0);
        inc_s[0] = 1'b1;
        clr_s[0] = 1'b1;
        tick();
        clr_s[0] = 1'b0;
        repeat (3) tick();
        inc_s[0] = 1'b0;
        tick();
        check("a_after_clr_bin", 32'(bin_a), 32'd0);

        // Ripple carry and blanking through 9, 10 and 100.
        repeat (9) pulse(1);
        check("b_9_digits", 32'(dg_b), 32'h0FF9);
        pulse(1);
        check("b_10_digits", 32'(dg_b), 32'h0F10);
        repeat (90) pulse(1);
        check("b_100_digits", 32'(dg_b), 32'h0100);
        check("b_100_bin", 32'(bin_b), 32'd100);

        // No blanking, two digits.
        repeat (12) pulse(2);
        check("c_12_digits", 32'(dg_c), 32'h12);

        // Request already high when reset releases counts on the first cycle.
        inc_s[2] = 1'b1;
        reset_n  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        inc_s[2] = 1'b0;
        tick();
        check("c_reset_held_bin", 32'(bin_c), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
